aud_recorder: RTL
=================

Name: aud_recorder

Overview:
- I2S capture path and the write-side counterpart of the playback DSP.
- Deserialises the left-channel word of each I2S frame from the codec ADC and writes it to the external 1M x 16 SRAM at consecutive addresses.
- Reports the index of the last written sample; the top level feeds this to the player's length input.
- Runs in the codec bit-clock domain, on the same clock as the playback path.

Parameters:
DATA_W, 16, sample width and number of bits shifted per frame
ADDR_W, 20, SRAM address width
MAX_ADDR, 20'hFFFFF, last writable address; recording auto-stops after writing it

Ports:
i_clk  in  1  codec bit clock (BCLK); all logic on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  one-cycle pulse: begin, or resume from pause
i_pause  in  1  one-cycle pulse: suspend recording
i_stop  in  1  one-cycle pulse: end recording
i_lrc  in  1  ADC LR clock; low = left channel (I2S mode)
i_data  in  1  ADC serial data, MSB first
o_address  out  ADDR_W  SRAM write address
o_data  out  DATA_W  SRAM write data
o_we  out  1  SRAM write strobe, one cycle per sample
o_len  out  ADDR_W  address of last sample written (0 if none)
o_full  out  1  set when MAX_ADDR has been written
o_busy  out  1  high in any state other than IDLE

Behaviour:
- One clock, i_clk. i_rst is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - o_address, o_data, o_len, bit counter and shift register all 0.
  - o_we=0, o_full=0, prev_lrc=0.
- All outputs are registered.
- Falling edge of i_lrc is detected as prev_lrc==1 && i_lrc==0; prev_lrc samples i_lrc every cycle.
- Command priority: i_stop > i_pause > i_start.
- States:
  - IDLE:
    - On i_start: go to WAIT. Clear o_address, o_len and o_full.
    - i_pause and i_stop are ignored.
  - WAIT:
    - On falling lrc edge: go to SHIFT, counter=0. Data in this edge cycle is the I2S delay bit and is discarded.
  - SHIFT:
    - Each cycle: shift = {shift[DATA_W-2:0], i_data}, counter += 1.
    - When counter==DATA_W-1: go to WRITE, o_data <= {shift[DATA_W-2:0], i_data}, o_we <= 1.
    - Further lrc edges are ignored while in SHIFT.
    - The right channel is never captured.
  - WRITE (exactly one cycle):
    - o_we=1, with o_address and o_data stable.
    - Next cycle: o_we=0 and o_len <= o_address.
    - If o_address==MAX_ADDR: o_full <= 1, address holds, go to IDLE.
    - Otherwise: o_address += 1, go to WAIT.
  - PAUSE:
    - Outputs hold, o_we=0.
    - On i_start: go to WAIT. Address is kept; no rewind.
    - On i_stop: go to IDLE.
- Latency: o_we is high in the 17th cycle after the edge-detect cycle (DATA_W+1 cycles).
- i_pause in WAIT or SHIFT: go to PAUSE next cycle; the partial word is discarded.
- i_stop in WAIT, SHIFT or PAUSE: go to IDLE next cycle; partial word discarded; o_len and o_address hold.
- i_pause or i_stop in the WRITE cycle: the write completes and the o_len/address update occurs. The next state is PAUSE or IDLE instead of WAIT, except that reaching MAX_ADDR always goes to IDLE.
- i_start outside IDLE and PAUSE is ignored.
- A re-start from IDLE rewinds to address 0, overwriting the previous recording.
- o_we is never asserted in IDLE, WAIT or PAUSE, and never asserted for two consecutive cycles.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous) and o_we drops the same instant. Any write in flight is abandoned.

Test Plan:
1. Reset: assert i_rst mid-SHIFT (or during an o_we=1 cycle) -> o_we=0 and state IDLE immediately; release; o_address=0, o_len=0, o_full=0, o_busy=0.
2. Basic record: i_start, then 3 I2S frames with left=16'h8001, 16'h1234, 16'hFFFF and right=16'hAAAA -> three o_we pulses at addresses 0,1,2 with exactly those data, each 17 cycles after its lrc falling edge; o_len=2; 16'hAAAA never written.
3. Pause/resume: i_pause after 8 bits of the 2nd frame -> no write for that frame; i_start, then frame 16'h5A5A -> written at address 1; o_len=1.
4. Full: MAX_ADDR=3, record 5 frames -> writes at 0..3 only; o_full=1, o_busy=0, o_len=3; 5th frame produces no o_we.
5. Stop/restart: record 2 words, i_stop, i_start, frame 16'h0F0F -> written at address 0; o_len=0 after that write.
6. Stop in the WRITE cycle: i_stop coincides with o_we=1 at address 4 -> write happens; o_len=4; IDLE next cycle; no further writes on later frames.

Source files
------------

// File: rtl/aud_recorder.sv
// aud_recorder: I2S capture path. Deserialises the left-channel word of each
// I2S frame from the codec ADC and writes it to external SRAM at consecutive
// addresses, reporting the address of the last sample written.
module aud_recorder #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 20,
  parameter logic [ADDR_W-1:0]  MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_len,
  output logic              o_full,
  output logic              o_busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_WRITE,
    S_PAUSE
  } state_t;

  state_t            state;
  logic              prev_lrc;
  logic [CNT_W-1:0]  bit_cnt;
  // Only DATA_W-1 bits need holding: the final bit is taken straight from
  // i_data when the completed word is handed to o_data.
  logic [DATA_W-2:0] shift_q;
  logic              lrc_fall;

  // Left slot starts on the falling LR clock edge.
  always_comb begin
    lrc_fall = prev_lrc & ~i_lrc;
  end

  // Capture state machine; every output is a register updated here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      prev_lrc  <= 1'b0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      o_address <= '0;
      o_data    <= '0;
      o_we      <= 1'b0;
      o_len     <= '0;
      o_full    <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      prev_lrc <= i_lrc;
      o_we     <= 1'b0;
      case (state)
        S_IDLE: begin
          // A fresh start rewinds, overwriting any previous recording.
          if (i_start) begin
            state     <= S_WAIT;
            o_busy    <= 1'b1;
            o_address <= '0;
            o_len     <= '0;
            o_full    <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i_stop) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else if (i_pause) begin
            state <= S_PAUSE;
          end else if (lrc_fall) begin
            // The bit in this cycle is the I2S one-bit delay; drop it.
            state   <= S_SHIFT;
            bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (i_stop) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else if (i_pause) begin
            state <= S_PAUSE;
          end else begin
            shift_q <= {shift_q[DATA_W-3:0], i_data};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              o_data <= {shift_q, i_data};
              o_we   <= 1'b1;
              state  <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // The write always completes; commands only choose where to go next.
          o_len <= o_address;
          if (o_address == MAX_ADDR) begin
            o_full <= 1'b1;
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            o_address <= o_address + 1'b1;
            if (i_stop) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else if (i_pause) begin
              state <= S_PAUSE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_PAUSE: begin
          if (i_stop) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else if (i_start) begin
            state <= S_WAIT;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
